// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state, error codes and default geometry for the capture path
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_SHORT   = 2'd2,
        ERR_ABORT   = 2'd3
    } err_t;

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;

endpackage

// File: rtl/capture_addr_gen.sv
// rtl/capture_addr_gen.sv - row/col/write counters and cropped frame-buffer write generation
module capture_addr_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              active,
    input  logic              pixel_valid,
    input  logic [7:0]        pixel_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              full_next
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TOTAL = IMG_W * IMG_H;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [CNT_W-1:0]  wr_count;
    logic              pv_q;
    logic              col_in_range;
    logic              row_in_range;
    logic              accept;
    logic              line_end;
    logic [ADDR_W-1:0] addr_calc;

    assign col_in_range = (col < COL_W'(IMG_W));
    assign row_in_range = (row < ROW_W'(IMG_H));
    assign accept       = active && pixel_valid && col_in_range && row_in_range;
    // A line ends on the falling edge of pixel_valid, seen against its registered copy.
    assign line_end     = active && pv_q && !pixel_valid;
    assign addr_calc    = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    // Includes a pixel accepted this same cycle, so a pixel coinciding with frame_done counts.
    assign full_next    = ((wr_count + {{ADDR_W{1'b0}}, accept}) == CNT_W'(TOTAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            wr_count <= '0;
            pv_q     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr_calc;
                wr_data <= pixel_in;
            end
            if (clear) begin
                col      <= '0;
                row      <= '0;
                wr_count <= '0;
                pv_q     <= 1'b0;
            end else if (active) begin
                pv_q <= pixel_valid;
                if (pixel_valid && col_in_range) begin
                    col <= col + COL_W'(1);
                end
                if (line_end) begin
                    col <= '0;
                    if (row_in_range) begin
                        row <= row + ROW_W'(1);
                    end
                end
                if (accept) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
            end else begin
                pv_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/capture_controller.sv
// rtl/capture_controller.sv - single-frame capture sequencer with watchdog into the frame buffer
module capture_controller
    import cam_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int TIMEOUT = 1000000,
    localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_req,
    input  logic              abort,
    input  logic [7:0]        pixel_in,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              capture_done,
    output logic [1:0]        err_code
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    state_t            state;
    err_t              err_q;
    logic [WDOG_W-1:0] wdog;
    logic              in_run;
    logic              abort_hit;
    logic              timeout_hit;
    logic              restart;
    logic              active;
    logic              clear;
    logic              full_next;

    assign in_run      = (state == ARMED) || (state == CAPTURE);
    assign abort_hit   = in_run && abort;
    assign timeout_hit = in_run && (wdog == WDOG_W'(TIMEOUT - 1));
    // A fresh frame_start mid-capture means the previous frame_done was lost: begin again.
    assign restart     = (state == CAPTURE) && frame_start && !abort_hit && !timeout_hit && !frame_done;
    assign active      = (state == CAPTURE) && !abort_hit && !timeout_hit && !restart;
    assign clear       = (state != CAPTURE) || restart;
    assign err_code    = err_q;

    capture_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .active      (active),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .full_next   (full_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            err_q        <= ERR_OK;
            wdog         <= '0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            capture_done <= 1'b0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (capture_req) begin
                        state <= ARMED;
                        err_q <= ERR_OK;
                        busy  <= 1'b1;
                    end
                end
                ARMED, CAPTURE: begin
                    wdog <= wdog + WDOG_W'(1);
                    if (abort_hit) begin
                        state        <= DONE;
                        err_q        <= ERR_ABORT;
                        capture_done <= 1'b1;
                        busy         <= 1'b0;
                    end else if (timeout_hit) begin
                        state        <= DONE;
                        err_q        <= ERR_TIMEOUT;
                        capture_done <= 1'b1;
                        busy         <= 1'b0;
                    end else if ((state == CAPTURE) && frame_done) begin
                        state        <= DONE;
                        err_q        <= full_next ? ERR_OK : ERR_SHORT;
                        capture_done <= 1'b1;
                        busy         <= 1'b0;
                    end else if (frame_start) begin
                        state <= CAPTURE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// tb/tb_capture_controller.sv - directed scoreboard bench for capture_controller
module tb_capture_controller;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 2;
    localparam int TIMEOUT = 100;
    localparam int ADDR_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              capture_req;
    logic              abort;
    logic [7:0]        pixel_in;
    logic              pixel_valid;
    logic              frame_start;
    logic              frame_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              capture_done;
    logic [1:0]        err_code;

    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_wr[$];
    logic [1:0] exp_done[$];
    wr_t  mon_e;
    logic [1:0] mon_err;
    int   n;

    capture_controller #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_req  (capture_req),
        .abort        (abort),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .capture_done (capture_done),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            checks++;
            assert (exp_wr.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%0d data=%h expected no write", wr_addr, wr_data);
            end
            if (exp_wr.size() != 0) begin
                mon_e = exp_wr.pop_front();
                checks++;
                assert ((wr_addr === mon_e.addr) && (wr_data === mon_e.data)) else begin
                    failures++;
                    $error("FAIL write observed addr=%0d data=%h expected addr=%0d data=%h",
                           wr_addr, wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
        if (capture_done) begin
            checks++;
            assert (exp_done.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_done observed err=%0d expected no done", err_code);
            end
            if (exp_done.size() != 0) begin
                mon_err = exp_done.pop_front();
                checks++;
                assert (err_code === mon_err) else begin
                    failures++;
                    $error("FAIL done_err observed=%0d expected=%0d", err_code, mon_err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_capture();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
        chk("busy_armed", {31'd0, busy}, 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] base, input int cnt, input int row);
        for (int i = 0; i < cnt; i++) begin
            pixel_valid = 1'b1;
            pixel_in    = base + 8'(i);
            if (i < IMG_W && row < IMG_H)
                exp_wr.push_back('{addr: ADDR_W'(row * IMG_W + i), data: base + 8'(i)});
            tick();
        end
        pixel_valid = 1'b0;
        tick();
    endtask

    task automatic full_frame();
        send_line(8'h10, 6, 0);
        send_line(8'h20, 6, 1);
        frame_done = 1'b1;
        exp_done.push_back(2'd0);
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0) && k < 50) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, (k < 50)}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        capture_req = 1'b0;
        abort       = 1'b0;
        pixel_in    = 8'h00;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        repeat (3) tick();
        chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, capture_done}, 32'd0);
        chk("reset_err", {30'd0, err_code}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full frame with extra columns cropped
        start_capture();
        full_frame();
        wait_drain("full_frame_drain");
        chk("full_busy_after", {31'd0, busy}, 32'd0);

        // Short frame: one line only
        start_capture();
        send_line(8'h50, 4, 0);
        frame_done = 1'b1;
        exp_done.push_back(2'd2);
        tick();
        frame_done = 1'b0;
        wait_drain("short_drain");
        tick();
        chk("short_err_held", {30'd0, err_code}, 32'd2);

        // Watchdog timeout with no frame_start
        capture_req = 1'b1;
        exp_done.push_back(2'd1);
        tick();
        capture_req = 1'b0;
        n = 0;
        while (!capture_done && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, 32'd100);
        tick();
        chk("timeout_busy_fall", {31'd0, busy}, 32'd0);
        chk("timeout_err_held", {30'd0, err_code}, 32'd1);

        // Abort mid-line together with a valid pixel
        start_capture();
        pixel_valid = 1'b1;
        pixel_in = 8'h30; exp_wr.push_back('{addr: 3'd0, data: 8'h30}); tick();
        pixel_in = 8'h31; exp_wr.push_back('{addr: 3'd1, data: 8'h31}); tick();
        pixel_in = 8'h32; abort = 1'b1; exp_done.push_back(2'd3); tick();
        abort = 1'b0;
        pixel_in = 8'h33; tick();
        pixel_in = 8'h34; tick();
        pixel_valid = 1'b0;
        wait_drain("abort_drain");
        repeat (3) tick();
        chk("abort_err_held", {30'd0, err_code}, 32'd3);

        // Traffic in IDLE and ARMED is ignored; capture_req while busy is not queued
        pixel_valid = 1'b1;
        frame_done  = 1'b1;
        pixel_in    = 8'hEE;
        repeat (3) tick();
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        capture_req = 1'b1;
        tick();
        pixel_valid = 1'b1;
        frame_done  = 1'b1;
        tick();
        capture_req = 1'b0;
        repeat (2) tick();
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        chk("armed_busy", {31'd0, busy}, 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
        full_frame();
        wait_drain("ignored_drain");
        repeat (10) tick();
        chk("ignored_err", {30'd0, err_code}, 32'd0);
        chk("ignored_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a capture
        capture_req = 1'b1;
        frame_done  = 1'b1;
        exp_done.push_back(2'd2);
        tick();
        capture_req = 1'b0;
        frame_done  = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        frame_done  = 1'b1;
        tick();
        frame_done  = 1'b0;
        wait_drain("pre_reset_short");
        start_capture();
        pixel_valid = 1'b1;
        pixel_in = 8'h40; exp_wr.push_back('{addr: 3'd0, data: 8'h40}); tick();
        pixel_in = 8'h41; exp_wr.push_back('{addr: 3'd1, data: 8'h41}); tick();
        pixel_in = 8'h42; exp_wr.push_back('{addr: 3'd2, data: 8'h42}); tick();
        pixel_valid = 1'b0;
        tick();
        tick();
        chk("writes_before_reset", exp_wr.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_done", {31'd0, capture_done}, 32'd0);
        chk("mid_reset_err", {30'd0, err_code}, 32'd0);
        chk("mid_reset_addr", {29'd0, wr_addr}, 32'd0);
        chk("mid_reset_data", {24'd0, wr_data}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_capture();
        full_frame();
        wait_drain("post_reset_drain");
        chk("post_reset_err", {30'd0, err_code}, 32'd0);

        repeat (3) tick();
        chk("final_wr_queue", exp_wr.size(), 32'd0);
        chk("final_done_queue", exp_done.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
